mul_ctrl: RTL

- Control FSM for the shift/add-free repeated-addition multiplier datapath (MUL).
- Sequences operand loads into the A and B registers, clears and accumulates the 16-bit product register, and steps the B down-counter until its zero flag is seen.
- Reports completion to the requester over a 4-phase start/done handshake.
- A watchdog iteration counter bounds the loop and flags a stuck `eqz`.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the repeated-addition multiplier.
// Used by the control FSM and the MUL datapath registers.
package mul_pkg;

  localparam int MUL_W = 16;
  localparam int ITER_W_DEF = 16;
  localparam logic [ITER_W_DEF-1:0] MAX_ITER_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier datapath.
// Loads A/B, accumulates P until eqz, watchdog bounds the loop.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int ITER_W = ITER_W_DEF,
  parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(MAX_ITER_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic eqz,
  output logic ldA,
  output logic ldB,
  output logic clrP,
  output logic ldP,
  output logic decB,
  output logic busy,
  output logic done,
  output logic err
);

  state_e state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    ldA     = 1'b0;
    ldB     = 1'b0;
    clrP    = 1'b0;
    ldP     = 1'b0;
    decB    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LDA;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LDA: begin
        ldA     = 1'b1;
        state_d = S_LDB;
      end
      S_LDB: begin
        ldB     = 1'b1;
        clrP    = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        // eqz outranks the watchdog so B == MAX_ITER still ends cleanly
        if (eqz) begin
          state_d = S_DONE;
        end else if (iter_q == MAX_ITER) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ldP    = 1'b1;
          decB   = 1'b1;
          iter_d = iter_q + ITER_W'(1);
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule
